mem_access_unit: RTL and testbench

- Parametrised load/store unit between the multicycle MIPS core and the Avalon-MM data bus.
- Accepts one CPU memory request at a time and holds a single Avalon transfer until waitrequest is released.
- Performs byte-lane steering, sign/zero extension and LWL/LWR merging, with optional bus byte-swap.
- Reports alignment and timeout faults; replaces the combinational data-selection/endian path for data accesses.

---
 rtl/mau_pkg.sv | 54 +++++
 rtl/mau_lane_align.sv | 72 +++++++
 rtl/mem_access_unit.sv | 198 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit.
// Contents: mau_op_t (CPU memory operation), mau_fault_t (response fault code),
// mau_state_t (FSM states), and helpers for store detection, alignment checks
// and byte-lane reversal.
package mau_pkg;

    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd7,
        SH  = 4'd8,
        SW  = 4'd9
    } mau_op_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        ALIGN   = 2'd1,
        TIMEOUT = 2'd2
    } mau_fault_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } mau_state_t;

    function automatic logic is_store(input mau_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halfword ops need an even address, word ops a word address; byte ops
    // and the unaligned-word pair LWL/LWR can never fault.
    function automatic logic is_misaligned(input mau_op_t op, input logic [1:0] off);
        case (op)
            LH, LHU, SH: return off[0];
            LW, SW:      return (off != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [3:0] swap4(input logic [3:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational byte-lane logic, all in CPU lane order.
// Load side : ld_op/ld_off/ld_word/ld_rt_old -> ld_data (extracted, extended
//             or LWL/LWR-merged result; 0 for store ops).
// Store side: st_op/st_off/st_wdata -> st_data (replicated store data) and
//             st_be (byte enables; 4'b1111 for loads).
module mau_lane_align
    import mau_pkg::*;
(
    input  mau_op_t     ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    input  logic [31:0] ld_rt_old,
    output logic [31:0] ld_data,
    input  mau_op_t     st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_wdata,
    output logic [31:0] st_data,
    output logic [3:0]  st_be
);

    logic [31:0] byte_sh_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [4:0]  lwl_sh_s;
    logic [4:0]  lwr_sh_s;

    // Load extraction: pick the addressed byte/halfword or merge for LWL/LWR.
    always_comb begin
        byte_sh_s = ld_word >> {ld_off, 3'b000};
        byte_s    = byte_sh_s[7:0];
        half_s    = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        // 8*(3-o) equals 8*(~o) for a two-bit offset.
        lwl_sh_s  = {~ld_off, 3'b000};
        lwr_sh_s  = {ld_off, 3'b000};
        ld_data   = 32'h0000_0000;
        case (ld_op)
            LB:      ld_data = {{24{byte_s[7]}}, byte_s};
            LBU:     ld_data = {24'h00_0000, byte_s};
            LH:      ld_data = {{16{half_s[15]}}, half_s};
            LHU:     ld_data = {16'h0000, half_s};
            LW:      ld_data = ld_word;
            LWL:     ld_data = (ld_word << lwl_sh_s) | (ld_rt_old & ~(32'hFFFF_FFFF << lwl_sh_s));
            LWR:     ld_data = (ld_word >> lwr_sh_s) | (ld_rt_old & ~(32'hFFFF_FFFF >> lwr_sh_s));
            default: ld_data = 32'h0000_0000;
        endcase
    end

    // Store steering: replicate data across lanes and enable only the target lanes.
    always_comb begin
        st_data = 32'h0000_0000;
        st_be   = 4'b1111;
        case (st_op)
            SB: begin
                st_be   = 4'b0001 << st_off;
                st_data = {4{st_wdata[7:0]}};
            end
            SH: begin
                st_be   = 4'b0011 << st_off;
                st_data = {2{st_wdata[15:0]}};
            end
            SW: begin
                st_be   = 4'b1111;
                st_data = st_wdata;
            end
            default: begin
                st_be   = 4'b1111;
                st_data = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the CPU and an Avalon-MM data bus.
// CPU side : req_valid/req_ready handshake with req_op, req_addr, req_wdata,
//            req_rt_old; one-cycle resp_valid strobe with resp_rdata, resp_fault.
// Bus side : address/read/write/writedata/byteenable held until waitrequest
//            drops; readdata captured on that edge. Optional lane swap and
//            stall timeout (TIMEOUT_CYCLES = 0 disables it).
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int SWAP_BYTES     = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  mau_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt_old,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output mau_fault_t        resp_fault,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    localparam logic        TMO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    mau_state_t        state_q, state_d;
    mau_op_t           op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rt_old_q, rt_old_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    mau_fault_t        resp_fault_q, resp_fault_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [31:0]       writedata_q, writedata_d;
    logic [3:0]        byteenable_q, byteenable_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       tmo_next_s;

    logic [31:0] rd_cpu_s;
    logic [31:0] ld_data_s;
    logic [31:0] st_data_s;
    logic [3:0]  st_be_s;

    // Bus readdata enters CPU lane order before extraction.
    assign rd_cpu_s = (SWAP_BYTES != 0) ? swap32(readdata) : readdata;

    mau_lane_align u_lane (
        .ld_op     (op_q),
        .ld_off    (off_q),
        .ld_word   (rd_cpu_s),
        .ld_rt_old (rt_old_q),
        .ld_data   (ld_data_s),
        .st_op     (req_op),
        .st_off    (req_addr[1:0]),
        .st_wdata  (req_wdata),
        .st_data   (st_data_s),
        .st_be     (st_be_s)
    );

    // Next-state and registered-output logic for the IDLE/BUS/RESP sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        rt_old_d     = rt_old_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        tmo_cnt_d    = tmo_cnt_q;
        tmo_next_s   = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    op_d        = req_op;
                    off_d       = req_addr[1:0];
                    rt_old_d    = req_rt_old;
                    req_ready_d = 1'b0;
                    if (is_misaligned(req_op, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = ALIGN;
                        resp_rdata_d = 32'h0000_0000;
                    end else begin
                        state_d      = BUS;
                        read_d       = !is_store(req_op);
                        write_d      = is_store(req_op);
                        address_d    = {req_addr[ADDR_W-1:2], 2'b00};
                        writedata_d  = (SWAP_BYTES != 0) ? swap32(st_data_s) : st_data_s;
                        byteenable_d = (SWAP_BYTES != 0) ? swap4(st_be_s) : st_be_s;
                        tmo_cnt_d    = 16'd0;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_d       = 1'b0;
                    write_d      = 1'b0;
                    resp_rdata_d = is_store(op_q) ? 32'h0000_0000 : ld_data_s;
                    resp_fault_d = NONE;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (TMO_EN) begin
                    tmo_cnt_d = tmo_next_s;
                    if (tmo_next_s == TMO_LIMIT) begin
                        read_d       = 1'b0;
                        write_d      = 1'b0;
                        resp_rdata_d = 32'h0000_0000;
                        resp_fault_d = TIMEOUT;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        state_d = BUS;
                    end
                end else begin
                    state_d = BUS;
                end
            end
            RESP: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                read_d      = 1'b0;
                write_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            op_q         <= LB;
            off_q        <= 2'b00;
            rt_old_q     <= 32'h0000_0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            resp_fault_q <= NONE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            writedata_q  <= 32'h0000_0000;
            byteenable_q <= 4'b0000;
            tmo_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            rt_old_q     <= rt_old_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_fault = resp_fault_q;
    assign read       = read_q;
    assign write      = write_q;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Two instances: dut 0 has straight
// lanes and an 8-cycle timeout, dut 1 has swapped lanes and no timeout.
// Expected values come from a behavioural model of the load/store rules.
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    mau_op_t     req_op      [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic [31:0] req_rt_old  [2];
    logic        resp_valid  [2];
    logic [31:0] resp_rdata  [2];
    mau_fault_t  resp_fault  [2];
    logic [31:0] address     [2];
    logic        read        [2];
    logic        write       [2];
    logic        waitrequest [2];
    logic [31:0] writedata   [2];
    logic [3:0]  byteenable  [2];
    logic [31:0] readdata    [2];

    int checks = 0;
    int errors = 0;

    logic [3:0]  last_be;
    logic [31:0] last_wd;
    logic [31:0] last_rdata;
    int          last_read_cycles;

    mem_access_unit #(.ADDR_W(32), .SWAP_BYTES(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_rt_old(req_rt_old[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
        .resp_fault(resp_fault[0]), .address(address[0]), .read(read[0]), .write(write[0]),
        .waitrequest(waitrequest[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
        .readdata(readdata[0])
    );

    mem_access_unit #(.ADDR_W(32), .SWAP_BYTES(1), .TIMEOUT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_rt_old(req_rt_old[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
        .resp_fault(resp_fault[1]), .address(address[1]), .read(read[1]), .write(write[1]),
        .waitrequest(waitrequest[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
        .readdata(readdata[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_bswap(input logic [31:0] w);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = w[8*(3-k) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] ref_beswap(input logic [3:0] b);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = b[3-k];
        return r;
    endfunction

    function automatic bit ref_misaligned(input mau_op_t op, input logic [31:0] a);
        if (op == LH || op == LHU || op == SH) return (a % 2) != 0;
        if (op == LW || op == SW) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input mau_op_t op, input int o,
                                             input logic [31:0] w, input logic [31:0] rt);
        logic [31:0] b;
        logic [31:0] h;
        int s;
        b = (w >> (8*o)) & 32'hFF;
        h = (w >> (16*(o/2))) & 32'hFFFF;
        case (op)
            LB:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            LBU: return b;
            LH:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            LHU: return h;
            LW:  return w;
            LWL: begin s = 8*(3-o); return (w << s) | (rt & ((32'd1 << s) - 32'd1)); end
            LWR: begin s = 8*o; return (w >> s) | (rt & ~(32'hFFFF_FFFF >> s)); end
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- one complete transaction ----------------
    task automatic run_txn(input int idx, input mau_op_t op, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rto,
                           input logic [31:0] rd_cpu, input int stalls);
        bit          st, mis, to, swp;
        int          o, tmo, n, guard;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_rd;
        mau_fault_t  e_f;
        st  = (op == SB || op == SH || op == SW);
        o   = int'(addr % 4);
        mis = ref_misaligned(op, addr);
        swp = (idx == 1);
        tmo = (idx == 0) ? 8 : 0;
        case (op)
            SB:      begin e_be = 4'(1 << o); e_wd = (wd & 32'hFF) * 32'h0101_0101; end
            SH:      begin e_be = 4'(3 << o); e_wd = (wd & 32'hFFFF) * 32'h0001_0001; end
            SW:      begin e_be = 4'b1111; e_wd = wd; end
            default: begin e_be = 4'b1111; e_wd = 32'd0; end
        endcase
        if (swp) begin e_be = ref_beswap(e_be); e_wd = ref_bswap(e_wd); end
        e_rd = st ? 32'd0 : ref_load(op, o, rd_cpu, rto);

        guard = 0;
        while (!req_ready[idx] && guard < 50) begin @(negedge clk); guard++; end
        checks++;
        if (req_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait dut%0d: req_ready=%b required 1", idx, req_ready[idx]);
        end
        req_valid[idx] = 1'b1; req_op[idx] = op; req_addr[idx] = addr;
        req_wdata[idx] = wd; req_rt_old[idx] = rto;
        @(negedge clk);
        // Keep a garbage request presented while busy; it must be ignored.
        req_op[idx]     = mau_op_t'(4'($urandom_range(0, 9)));
        req_addr[idx]   = $urandom;
        req_wdata[idx]  = $urandom;
        req_rt_old[idx] = $urandom;
        last_read_cycles = 0;
        to = 1'b0;
        if (!mis) begin
            n = 0;
            forever begin
                if (read[idx] === 1'b1) last_read_cycles++;
                checks++;
                if ({read[idx], write[idx]} !== {!st, st}) begin
                    errors++;
                    $display("FAIL bus_rw dut%0d: rw=%b%b required %b%b", idx, read[idx], write[idx], !st, st);
                end
                checks++;
                if (address[idx] !== {addr[31:2], 2'b00}) begin
                    errors++;
                    $display("FAIL bus_addr dut%0d: got %h required %h", idx, address[idx], {addr[31:2], 2'b00});
                end
                checks++;
                if (byteenable[idx] !== e_be) begin
                    errors++;
                    $display("FAIL bus_be dut%0d: got %b required %b", idx, byteenable[idx], e_be);
                end
                if (st) begin
                    checks++;
                    if (writedata[idx] !== e_wd) begin
                        errors++;
                        $display("FAIL bus_wdata dut%0d: got %h required %h", idx, writedata[idx], e_wd);
                    end
                end
                last_be = byteenable[idx];
                last_wd = writedata[idx];
                if (n < stalls) begin
                    waitrequest[idx] = 1'b1; readdata[idx] = $urandom;
                end else begin
                    waitrequest[idx] = 1'b0;
                    readdata[idx] = swp ? ref_bswap(rd_cpu) : rd_cpu;
                end
                @(negedge clk);
                if (n >= stalls) break;
                n++;
                if (tmo != 0 && n == tmo) begin to = 1'b1; break; end
            end
        end
        e_f = mis ? ALIGN : (to ? TIMEOUT : NONE);
        if (mis || to) e_rd = 32'd0;
        checks++;
        if ({resp_valid[idx], read[idx], write[idx], req_ready[idx]} !== 4'b1000) begin
            errors++;
            $display("FAIL resp_ctl dut%0d: valid/rd/wr/ready=%b%b%b%b required 1000", idx,
                     resp_valid[idx], read[idx], write[idx], req_ready[idx]);
        end
        checks++;
        if (resp_fault[idx] !== e_f) begin
            errors++;
            $display("FAIL resp_fault dut%0d: got %0d required %0d", idx, resp_fault[idx], e_f);
        end
        checks++;
        if (resp_rdata[idx] !== e_rd) begin
            errors++;
            $display("FAIL resp_rdata dut%0d op %0d addr %h: got %h required %h", idx, op, addr, resp_rdata[idx], e_rd);
        end
        last_rdata = resp_rdata[idx];
        req_valid[idx] = 1'b0;
        waitrequest[idx] = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp_valid[idx], req_ready[idx]} !== 2'b01) begin
            errors++;
            $display("FAIL resp_end dut%0d: valid/ready=%b%b required 01", idx, resp_valid[idx], req_ready[idx]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset[0] = 1'b1; reset[1] = 1'b1;
        repeat (2) @(negedge clk);
        reset[0] = 1'b0; reset[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({req_ready[i], resp_valid[i], resp_rdata[i], resp_fault[i], read[i], write[i],
                 address[i], writedata[i], byteenable[i]} !== {1'b1, 1'b0, 32'd0, NONE, 1'b0, 1'b0,
                 32'd0, 32'd0, 4'b0000}) begin
                errors++;
                $display("FAIL reset_values dut%0d: ready=%b valid=%b rdata=%h fault=%0d rd=%b wr=%b addr=%h wd=%h be=%b",
                         i, req_ready[i], resp_valid[i], resp_rdata[i], resp_fault[i], read[i], write[i],
                         address[i], writedata[i], byteenable[i]);
            end
        end
    endtask

    task automatic test_lw_basic();
        run_txn(0, LW, 32'h100, 32'd0, 32'd0, 32'h1122_3344, 0);
        checks++;
        if (last_read_cycles != 1 || last_rdata !== 32'h1122_3344) begin
            errors++;
            $display("FAIL lw_basic: read_cycles=%0d rdata=%h required 1 and 11223344", last_read_cycles, last_rdata);
        end
        run_txn(1, LW, 32'h100, 32'd0, 32'd0, 32'h1122_3344, 0);
    endtask

    task automatic test_lb_stall();
        run_txn(0, LB, 32'h103, 32'd0, 32'd0, 32'h80FF_FFFF, 3);
        checks++;
        if (last_read_cycles != 4 || last_rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_stall: read_cycles=%0d rdata=%h required 4 and ffffff80", last_read_cycles, last_rdata);
        end
        run_txn(0, LBU, 32'h103, 32'd0, 32'd0, 32'h80FF_FFFF, 0);
        checks++;
        if (last_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu: rdata=%h required 00000080", last_rdata);
        end
        run_txn(1, LH, 32'h102, 32'd0, 32'd0, 32'h9234_5678, 2);
    endtask

    task automatic test_sh();
        run_txn(0, SH, 32'h202, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
        checks++;
        if (last_be !== 4'b1100 || last_wd !== 32'hBEEF_BEEF) begin
            errors++;
            $display("FAIL sh_straight: be=%b wd=%h required 1100 beefbeef", last_be, last_wd);
        end
        run_txn(1, SH, 32'h202, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
        checks++;
        if (last_be !== 4'b0011 || last_wd !== 32'hEFBE_EFBE) begin
            errors++;
            $display("FAIL sh_swapped: be=%b wd=%h required 0011 efbeefbe", last_be, last_wd);
        end
        run_txn(0, SB, 32'h301, 32'h0000_00A5, 32'd0, 32'd0, 1);
    endtask

    task automatic test_align();
        run_txn(0, LW, 32'h101, 32'd0, 32'd0, 32'h1234_5678, 0);
        run_txn(1, LH, 32'h001, 32'd0, 32'd0, 32'h1234_5678, 0);
        run_txn(0, SW, 32'h002, 32'h5555_AAAA, 32'd0, 32'd0, 0);
    endtask

    task automatic test_timeout();
        run_txn(0, LW, 32'h400, 32'd0, 32'd0, 32'hCAFE_F00D, 20);
        checks++;
        if (last_read_cycles != 8) begin
            errors++;
            $display("FAIL timeout_len: read_cycles=%0d required 8", last_read_cycles);
        end
        run_txn(0, LW, 32'h404, 32'd0, 32'd0, 32'hCAFE_F00D, 0);
        run_txn(0, SW, 32'h408, 32'h0102_0304, 32'd0, 32'd0, 8);
        run_txn(0, LW, 32'h40C, 32'd0, 32'd0, 32'h7777_8888, 7);
    endtask

    task automatic test_lwl_lwr();
        run_txn(0, LWL, 32'h1, 32'd0, 32'h1122_3344, 32'hAABB_CCDD, 0);
        checks++;
        if (last_rdata !== 32'hCCDD_3344) begin
            errors++;
            $display("FAIL lwl: rdata=%h required ccdd3344", last_rdata);
        end
        run_txn(1, LWR, 32'h2, 32'd0, 32'h1122_3344, 32'hAABB_CCDD, 1);
        checks++;
        if (last_rdata !== 32'h1122_AABB) begin
            errors++;
            $display("FAIL lwr: rdata=%h required 1122aabb", last_rdata);
        end
    endtask

    task automatic test_reset_mid();
        req_valid[0] = 1'b1; req_op[0] = LW; req_addr[0] = 32'h300;
        waitrequest[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (read[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: read=%b required 1", read[0]);
        end
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        waitrequest[0] = 1'b0;
        checks++;
        if ({read[0], write[0], req_ready[0], resp_valid[0], address[0], byteenable[0]} !==
            {1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid: rd=%b wr=%b ready=%b valid=%b addr=%h be=%b required 0 0 1 0 0 0",
                     read[0], write[0], req_ready[0], resp_valid[0], address[0], byteenable[0]);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (resp_valid[0] !== 1'b0 || read[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: valid=%b read=%b required 0 0", resp_valid[0], read[0]);
            end
        end
        run_txn(0, LHU, 32'h302, 32'd0, 32'd0, 32'hBEEF_0000, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            run_txn(i % 2, mau_op_t'(4'(i + 2)), 32'h500 + 32'(4 * i), $urandom, $urandom, $urandom, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int idx;
            idx = i % 2;
            run_txn(idx, mau_op_t'(4'($urandom_range(0, 9))), $urandom, $urandom, $urandom, $urandom,
                    (idx == 0) ? int'($urandom_range(0, 10)) : int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_op[i] = LB; req_addr[i] = 32'd0;
            req_wdata[i] = 32'd0; req_rt_old[i] = 32'd0; waitrequest[i] = 1'b0; readdata[i] = 32'd0;
        end
        @(negedge clk);
        test_reset();
        test_lw_basic();
        test_lb_stall();
        test_sh();
        test_align();
        test_timeout();
        test_lwl_lwr();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
